// File: rtl/ap3_dsp_pkg.sv
// Shared types and constants for the DSP multiply-accumulate sequencer.
// Holds the FSM state encoding, DSP mode-select codes and the result width.
package ap3_dsp_pkg;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ACCUM = 2'd1,
        S_DRAIN = 2'd2,
        S_OUT   = 2'd3
    } state_t;

    localparam logic [1:0] MAC_MODE_MUL = 2'b00;
    localparam logic [1:0] MAC_MODE_ACC = 2'b01;

    localparam int RES_W   = 64;
    localparam int DRAIN_W = 4;

endpackage

// File: rtl/dsp_mac_seq.sv
// Runs one external DSP block as a length-N multiply-accumulate engine:
// streams beats in, waits out the DSP pipeline, then hands off the 64-bit sum.
//
// state | meaning
// IDLE  | waiting for START; no input accepted
// ACCUM | accepting beats, each handshake enables the DSP
// DRAIN | counting down DSP pipeline latency before capture
// OUT   | result held on OUT_DATA until OUT_READY
module dsp_mac_seq
    import ap3_dsp_pkg::*;
#(
    parameter int         LEN_W    = 8,
    parameter int         DSP_LAT  = 2,
    parameter logic [1:0] MODE     = MAC_MODE_ACC,
    parameter logic [1:0] OSEL_CFG = 2'b00
) (
    input  logic             QCK,
    input  logic             QRT,
    input  logic             START,
    input  logic [LEN_W-1:0] LEN,
    input  logic             RND,
    input  logic             SAT,
    output logic             BUSY,
    input  logic             IN_VALID,
    output logic             IN_READY,
    input  logic [31:0]      IN_COEF,
    input  logic [31:0]      IN_OPER,
    output logic [31:0]      DSP_COEF,
    output logic [31:0]      DSP_OPER,
    output logic             DSP_ENABLE,
    output logic             DSP_CLR,
    output logic             DSP_RND,
    output logic             DSP_SAT,
    output logic [1:0]       DSP_MODE_SEL,
    output logic [1:0]       DSP_OUT_SEL,
    input  logic [RES_W-1:0] DSP_MAC_OUT,
    output logic             OUT_VALID,
    input  logic             OUT_READY,
    output logic [RES_W-1:0] OUT_DATA
);

    // drain counts the edges after the last beat still needed before MAC_OUT is final
    localparam logic [DRAIN_W-1:0] DRAIN_INIT = DRAIN_W'(DSP_LAT - 1);

    state_t             state;
    state_t             state_nxt;
    logic [LEN_W-1:0]   remain;
    logic               first;
    logic [DRAIN_W-1:0] drain;
    logic               rnd_q;
    logic               sat_q;
    logic [RES_W-1:0]   out_data;

    logic beat;
    logic last_beat;
    logic drain_done;
    logic cmd_accept;

    assign cmd_accept = (state == S_IDLE) && START;
    assign beat       = (state == S_ACCUM) && IN_VALID;
    assign last_beat  = beat && (remain == LEN_W'(1));
    assign drain_done = (state == S_DRAIN) && (drain == '0);

    always_ff @(posedge QCK or posedge QRT) begin
        if (QRT) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE: begin
                if (START) begin
                    state_nxt = (LEN != '0) ? S_ACCUM : S_OUT;
                end
            end
            S_ACCUM: begin
                if (last_beat) begin
                    state_nxt = S_DRAIN;
                end
            end
            S_DRAIN: begin
                if (drain_done) begin
                    state_nxt = S_OUT;
                end
            end
            S_OUT: begin
                if (OUT_READY) begin
                    state_nxt = S_IDLE;
                end
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    always_comb begin
        BUSY       = 1'b0;
        IN_READY   = 1'b0;
        DSP_ENABLE = 1'b0;
        DSP_CLR    = 1'b0;
        OUT_VALID  = 1'b0;
        case (state)
            S_IDLE: begin
                BUSY = 1'b0;
            end
            S_ACCUM: begin
                BUSY       = 1'b1;
                IN_READY   = 1'b1;
                DSP_ENABLE = IN_VALID;
                DSP_CLR    = IN_VALID & first;
            end
            S_DRAIN: begin
                BUSY = 1'b1;
            end
            S_OUT: begin
                BUSY      = 1'b1;
                OUT_VALID = 1'b1;
            end
            default: begin
                BUSY = 1'b0;
            end
        endcase
    end

    always_ff @(posedge QCK or posedge QRT) begin
        if (QRT) begin
            remain <= '0;
            first  <= 1'b0;
            rnd_q  <= 1'b0;
            sat_q  <= 1'b0;
        end else if (cmd_accept) begin
            remain <= LEN;
            first  <= 1'b1;
            rnd_q  <= RND;
            sat_q  <= SAT;
        end else if (beat) begin
            remain <= remain - LEN_W'(1);
            first  <= 1'b0;
        end
    end

    always_ff @(posedge QCK or posedge QRT) begin
        if (QRT) begin
            drain <= '0;
        end else if (last_beat) begin
            drain <= DRAIN_INIT;
        end else if ((state == S_DRAIN) && (drain != '0)) begin
            drain <= drain - DRAIN_W'(1);
        end
    end

    // Zero-length commands publish an explicit zero rather than a stale result.
    always_ff @(posedge QCK or posedge QRT) begin
        if (QRT) begin
            out_data <= '0;
        end else if (cmd_accept && (LEN == '0)) begin
            out_data <= '0;
        end else if (drain_done) begin
            out_data <= DSP_MAC_OUT;
        end
    end

    assign DSP_COEF     = IN_COEF;
    assign DSP_OPER     = IN_OPER;
    assign DSP_RND      = rnd_q;
    assign DSP_SAT      = sat_q;
    assign DSP_MODE_SEL = MODE;
    assign DSP_OUT_SEL  = OSEL_CFG;
    assign OUT_DATA     = out_data;

endmodule

// File: tb/tb_dsp_mac_seq.sv
// Bench for dsp_mac_seq: two builds (DSP_LAT=2 and DSP_LAT=1) share one stimulus
// stream, each driving its own behavioural DSP; sums are predicted from beat products.
module tb_dsp_mac_seq;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst = 1'b0;
    logic        start = 1'b0;
    logic [7:0]  len = 8'd0;
    logic        rnd = 1'b0;
    logic        sat = 1'b0;
    logic        in_valid = 1'b0;
    logic [31:0] coef = 32'd0;
    logic [31:0] oper = 32'd0;
    logic        rdy_a = 1'b0;
    logic        rdy_b = 1'b1;

    logic        busy_a, in_ready_a, en_a, clr_a, drnd_a, dsat_a, ov_a;
    logic [31:0] dc_a, do_a;
    logic [1:0]  ms_a, os_a;
    logic [63:0] mac_a, od_a;

    logic        busy_b, in_ready_b, en_b, clr_b, drnd_b, dsat_b, ov_b;
    logic [31:0] dc_b, do_b;
    logic [1:0]  ms_b, os_b;
    logic [63:0] mac_b, od_b;

    int total = 0;
    int bad = 0;

    logic [31:0] cq[$];
    logic [31:0] oq[$];

    dsp_mac_seq #(.LEN_W(8), .DSP_LAT(2), .MODE(2'b01), .OSEL_CFG(2'b00)) dut_a (
        .QCK(clk), .QRT(rst), .START(start), .LEN(len), .RND(rnd), .SAT(sat),
        .BUSY(busy_a), .IN_VALID(in_valid), .IN_READY(in_ready_a),
        .IN_COEF(coef), .IN_OPER(oper), .DSP_COEF(dc_a), .DSP_OPER(do_a),
        .DSP_ENABLE(en_a), .DSP_CLR(clr_a), .DSP_RND(drnd_a), .DSP_SAT(dsat_a),
        .DSP_MODE_SEL(ms_a), .DSP_OUT_SEL(os_a), .DSP_MAC_OUT(mac_a),
        .OUT_VALID(ov_a), .OUT_READY(rdy_a), .OUT_DATA(od_a)
    );

    dsp_mac_seq #(.LEN_W(8), .DSP_LAT(1), .MODE(2'b01), .OSEL_CFG(2'b00)) dut_b (
        .QCK(clk), .QRT(rst), .START(start), .LEN(len), .RND(rnd), .SAT(sat),
        .BUSY(busy_b), .IN_VALID(in_valid), .IN_READY(in_ready_b),
        .IN_COEF(coef), .IN_OPER(oper), .DSP_COEF(dc_b), .DSP_OPER(do_b),
        .DSP_ENABLE(en_b), .DSP_CLR(clr_b), .DSP_RND(drnd_b), .DSP_SAT(dsat_b),
        .DSP_MODE_SEL(ms_b), .DSP_OUT_SEL(os_b), .DSP_MAC_OUT(mac_b),
        .OUT_VALID(ov_b), .OUT_READY(rdy_b), .OUT_DATA(od_b)
    );

    // Behavioural DSPs: accumulator plus (DSP_LAT-1) output register stages.
    logic [63:0] acc_a = 64'd0;
    logic [63:0] dly_a = 64'd0;
    logic [63:0] acc_b = 64'd0;
    wire  [63:0] prod_a = {32'd0, dc_a} * {32'd0, do_a};
    wire  [63:0] prod_b = {32'd0, dc_b} * {32'd0, do_b};

    always @(posedge clk) begin
        if (en_a) acc_a <= clr_a ? prod_a : acc_a + prod_a;
        dly_a <= acc_a;
        if (en_b) acc_b <= clr_b ? prod_b : acc_b + prod_b;
    end
    assign mac_a = dly_a;
    assign mac_b = acc_b;

    initial begin
        #200000;
        $display("FAIL watchdog: observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic start_cmd(input logic [7:0] l, input logic r, input logic s);
        start = 1'b1;
        len   = l;
        rnd   = r;
        sat   = s;
        tick();
        start = 1'b0;
        len   = 8'($urandom);
        rnd   = ~r;
        sat   = ~s;
        chk("start_busy", {63'd0, busy_a}, 64'd1);
        chk("start_in_ready", {63'd0, in_ready_a}, {63'd0, l != 8'd0});
        chk("start_rnd", {63'd0, drnd_a}, {63'd0, r});
        chk("start_sat", {63'd0, dsat_a}, {63'd0, s});
    endtask

    // Drains cq/oq into the DUT; alt forces a 1/0 valid pattern, else bub_pct random bubbles.
    task automatic feed(input bit alt, input int bub_pct, output logic [63:0] sum);
        bit first = 1'b1;
        bit v = 1'b0;
        sum = 64'd0;
        while (cq.size() > 0) begin
            if (alt) v = ~v;
            else     v = ($urandom_range(99) >= bub_pct);
            in_valid = v;
            coef = v ? cq[0] : $urandom;
            oper = v ? oq[0] : $urandom;
            #1;
            chk("beat_in_ready", {63'd0, in_ready_a}, 64'd1);
            chk("beat_enable", {63'd0, en_a}, {63'd0, v});
            chk("beat_clr", {63'd0, clr_a}, {63'd0, v & first});
            chk("beat_coef_pass", {32'd0, dc_a}, {32'd0, coef});
            tick();
            if (v) begin
                sum += {32'd0, cq[0]} * {32'd0, oq[0]};
                void'(cq.pop_front());
                void'(oq.pop_front());
                first = 1'b0;
            end
        end
        in_valid = 1'b0;
    endtask

    task automatic wait_out(input int exp_edges, input logic [63:0] exp_data, input string tag);
        int n = 0;
        while (!ov_a && n < 50) begin
            tick();
            n++;
        end
        chk({tag, "_latency"}, 64'(n), 64'(exp_edges));
        chk({tag, "_data"}, od_a, exp_data);
    endtask

    task automatic release_out();
        rdy_a = 1'b1;
        tick();
        rdy_a = 1'b0;
        chk("release_busy", {63'd0, busy_a}, 64'd0);
        chk("release_valid", {63'd0, ov_a}, 64'd0);
    endtask

    initial begin
        logic [63:0] sum;
        int          l;
        int          hold;

        #1 rst = 1'b1;
        tick();
        tick();
        chk("rst_busy", {63'd0, busy_a}, 64'd0);
        chk("rst_in_ready", {63'd0, in_ready_a}, 64'd0);
        chk("rst_enable", {63'd0, en_a}, 64'd0);
        chk("rst_out_valid", {63'd0, ov_a}, 64'd0);
        chk("rst_out_data", od_a, 64'd0);
        chk("rst_rnd_sat", {62'd0, drnd_a, dsat_a}, 64'd0);
        chk("mode_sel", {62'd0, ms_a}, 64'd1);
        chk("out_sel", {62'd0, os_a}, 64'd0);
        rst = 1'b0;
        tick();

        // basic sum
        start_cmd(8'd3, 1'b0, 1'b0);
        cq = '{32'd2, 32'd4, 32'd1};
        oq = '{32'd3, 32'd5, 32'd7};
        feed(1'b0, 0, sum);
        wait_out(2, 64'd33, "basic");
        release_out();

        // bubbles and back-pressure
        start_cmd(8'd4, 1'b1, 1'b0);
        cq = '{32'd1, 32'd1, 32'd1, 32'd1};
        oq = '{32'd1, 32'd1, 32'd1, 32'd1};
        feed(1'b1, 0, sum);
        wait_out(2, 64'd4, "bp");
        for (int i = 0; i < 4; i++) begin
            tick();
            chk("bp_hold_valid", {63'd0, ov_a}, 64'd1);
            chk("bp_hold_data", od_a, 64'd4);
        end
        chk("bp_rnd_latched", {63'd0, drnd_a}, 64'd1);
        release_out();

        // zero length, with IN_VALID held high throughout
        in_valid = 1'b1;
        #1 chk("zero_idle_enable", {63'd0, en_a}, 64'd0);
        start_cmd(8'd0, 1'b0, 1'b0);
        chk("zero_valid", {63'd0, ov_a}, 64'd1);
        chk("zero_data", od_a, 64'd0);
        chk("zero_enable", {63'd0, en_a}, 64'd0);
        release_out();
        chk("zero_enable_after", {63'd0, en_a}, 64'd0);
        in_valid = 1'b0;

        // back-to-back commands
        start_cmd(8'd2, 1'b0, 1'b0);
        cq = '{32'd3, 32'd3};
        oq = '{32'd3, 32'd3};
        feed(1'b0, 0, sum);
        wait_out(2, 64'd18, "b2b_first");
        release_out();
        start_cmd(8'd1, 1'b0, 1'b0);
        cq = '{32'd5};
        oq = '{32'd5};
        feed(1'b0, 0, sum);
        wait_out(2, 64'd25, "b2b_second");
        release_out();

        // asynchronous reset mid-accumulation
        start_cmd(8'd4, 1'b1, 1'b1);
        cq = '{32'd9};
        oq = '{32'd9};
        feed(1'b0, 0, sum);
        in_valid = 1'b1;
        coef = 32'd11;
        oper = 32'd11;
        #2 rst = 1'b1;
        #1;
        chk("arst_busy", {63'd0, busy_a}, 64'd0);
        chk("arst_in_ready", {63'd0, in_ready_a}, 64'd0);
        chk("arst_enable_clr", {62'd0, en_a, clr_a}, 64'd0);
        chk("arst_rnd_sat", {62'd0, drnd_a, dsat_a}, 64'd0);
        chk("arst_out", {63'd0, ov_a}, 64'd0);
        chk("arst_data", od_a, 64'd0);
        #1 rst = 1'b0;
        in_valid = 1'b0;
        tick();
        chk("arst_stays_idle", {63'd0, busy_a}, 64'd0);
        start_cmd(8'd1, 1'b0, 1'b0);
        cq = '{32'd6};
        oq = '{32'd7};
        feed(1'b0, 0, sum);
        wait_out(2, 64'd42, "arst_next");
        release_out();

        // ignored START during DRAIN; DSP_LAT=1 build checked alongside
        start_cmd(8'd3, 1'b0, 1'b1);
        for (int i = 0; i < 3; i++) begin
            cq.push_back($urandom);
            oq.push_back($urandom);
        end
        feed(1'b0, 0, sum);
        start = 1'b1;
        len   = 8'd9;
        rnd   = 1'b1;
        sat   = 1'b0;
        tick();
        start = 1'b0;
        chk("lat1_valid", {63'd0, ov_b}, 64'd1);
        chk("lat1_data", od_b, sum);
        chk("lat2_not_yet", {63'd0, ov_a}, 64'd0);
        tick();
        chk("lat2_valid", {63'd0, ov_a}, 64'd1);
        chk("lat2_data", od_a, sum);
        chk("lat1_idle_after", {62'd0, busy_b, in_ready_b}, 64'd0);
        chk("ign_rnd_sat", {62'd0, drnd_a, dsat_a}, 64'd1);
        release_out();
        chk("ign_no_accum", {63'd0, in_ready_a}, 64'd0);

        // randomized commands
        for (int k = 0; k < 8; k++) begin
            l = $urandom_range(1, 12);
            for (int i = 0; i < l; i++) begin
                cq.push_back($urandom);
                oq.push_back($urandom);
            end
            start_cmd(8'(l), 1'($urandom), 1'($urandom));
            feed(1'b0, $urandom_range(0, 60), sum);
            wait_out(2, sum, "rand");
            hold = $urandom_range(0, 3);
            for (int i = 0; i < hold; i++) begin
                tick();
                chk("rand_hold", od_a, sum);
            end
            release_out();
        end

        // maximum length: 255 beats, no wrap
        for (int i = 0; i < 255; i++) begin
            cq.push_back($urandom);
            oq.push_back($urandom);
        end
        start_cmd(8'hFF, 1'b0, 1'b0);
        feed(1'b0, 0, sum);
        wait_out(2, sum, "maxlen");
        release_out();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
